audio_sfx_sequencer: RTL and testbench

AUDIO_SFX_SEQUENCER -- requirements
Module: audio_sfx_sequencer

---
 rtl/audio_sfx_sequencer.sv | 174 +++++++++++++++++
 tb/tb_audio_sfx_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/audio_sfx_sequencer.sv
// audio_sfx_sequencer
//   Plays short sound effects from a fixed note ROM. Each note holds a
//   frequency for a whole number of ticks. A silent gap separates the notes
//   of one effect. The sequencer drives a downstream tone generator.
//
// Ports
//   i_clk   : clock, all logic on the rising edge
//   i_rst   : synchronous active-high reset
//   i_trig  : one-cycle request to start the effect selected by i_sfx
//   i_sfx   : effect select (0 laser, 1 explosion, 2 coin, 3 stop)
//   o_freq  : current note frequency in Hz, 0 = silence
//   o_busy  : high while an effect is playing, gaps included
//   o_done  : one-cycle pulse when an effect completes on its own
module audio_sfx_sequencer #(
    parameter int CLK_FREQ  = 12000000,
    parameter int TICK_HZ   = 1000,
    parameter int GAP_TICKS = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_trig,
    input  logic [1:0]  i_sfx,
    output logic [23:0] o_freq,
    output logic        o_busy,
    output logic        o_done
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int DIV_W = $clog2(DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    // Tick counter covers both the 12-bit note durations and the gap length.
    localparam int TICK_W = 16;
    localparam logic [TICK_W-1:0] GAP_LAST =
        TICK_W'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // ROM entry layout: {freq[23:0], duration[11:0], last}
    function automatic logic [36:0] rom_entry(input logic [2:0] addr);
        logic [36:0] e;
        case (addr)
            3'd0:    e = {24'd880,  12'd50,  1'b0};
            3'd1:    e = {24'd660,  12'd50,  1'b0};
            3'd2:    e = {24'd440,  12'd50,  1'b1};
            3'd3:    e = {24'd110,  12'd100, 1'b0};
            3'd4:    e = {24'd80,   12'd100, 1'b0};
            3'd5:    e = {24'd60,   12'd200, 1'b1};
            3'd6:    e = {24'd988,  12'd60,  1'b0};
            3'd7:    e = {24'd1319, 12'd200, 1'b1};
            default: e = '0;
        endcase
        return e;
    endfunction

    // Effect n starts at ROM address 3*n.
    function automatic logic [2:0] first_addr(input logic [1:0] sfx);
        logic [2:0] a;
        case (sfx)
            2'd0:    a = 3'd0;
            2'd1:    a = 3'd3;
            default: a = 3'd6;
        endcase
        return a;
    endfunction

    state_t            r_state;
    logic [2:0]        r_addr;
    logic [DIV_W-1:0]  r_div;
    logic [TICK_W-1:0] r_ticks;
    logic              r_done;

    state_t            w_state_nxt;
    logic [2:0]        w_addr_nxt;
    logic              w_clr;
    logic              w_done_nxt;

    logic [36:0]       w_entry;
    logic [23:0]       w_entry_freq;
    logic [11:0]       w_entry_dur;
    logic              w_entry_last;
    logic [11:0]       w_dur_eff;
    logic              w_tick_end;
    logic              w_note_end;
    logic              w_gap_end;

    assign w_entry      = rom_entry(r_addr);
    assign w_entry_freq = w_entry[36:13];
    assign w_entry_dur  = w_entry[12:1];
    assign w_entry_last = w_entry[0];
    // A zero duration would never expire; play it as one tick.
    assign w_dur_eff    = (w_entry_dur == 12'd0) ? 12'd1 : w_entry_dur;

    assign w_tick_end = (r_div == DIV_LAST);
    assign w_note_end = w_tick_end && (r_ticks == {4'd0, w_dur_eff - 12'd1});
    assign w_gap_end  = w_tick_end && (r_ticks == GAP_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_addr  <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Counters restart on every NOTE/GAP entry so durations never drift.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_clr || (r_state == S_IDLE)) begin
            r_div   <= '0;
            r_ticks <= '0;
        end else if (w_tick_end) begin
            r_div   <= '0;
            r_ticks <= r_ticks + 1'b1;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_clr       = 1'b0;
        w_done_nxt  = 1'b0;
        if (i_trig) begin
            // A new trigger always wins, even over a note that is just ending.
            w_clr = 1'b1;
            if (i_sfx == 2'd3) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = S_NOTE;
                w_addr_nxt  = first_addr(i_sfx);
            end
        end else begin
            case (r_state)
                S_NOTE: begin
                    if (w_note_end) begin
                        w_clr = 1'b1;
                        if (w_entry_last) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end else if (GAP_TICKS == 0) begin
                            w_state_nxt = S_NOTE;
                            w_addr_nxt  = r_addr + 3'd1;
                        end else begin
                            w_state_nxt = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        w_clr       = 1'b1;
                        w_state_nxt = S_NOTE;
                        w_addr_nxt  = r_addr + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign o_freq = (r_state == S_NOTE) ? w_entry_freq : 24'd0;
    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;

endmodule

// File: tb/tb_audio_sfx_sequencer.sv
module tb_audio_sfx_sequencer;

    logic        clk;
    logic        rst;
    logic        trig_a;
    logic        trig_b;
    logic [1:0]  sfx;
    logic [23:0] freq_a;
    logic [23:0] freq_b;
    logic        busy_a;
    logic        busy_b;
    logic        done_a;
    logic        done_b;

    int n_checks = 0;
    int n_errors = 0;

    audio_sfx_sequencer #(
        .CLK_FREQ (12000),
        .TICK_HZ  (1000),
        .GAP_TICKS(10)
    ) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .i_trig(trig_a),
        .i_sfx (sfx),
        .o_freq(freq_a),
        .o_busy(busy_a),
        .o_done(done_a)
    );

    audio_sfx_sequencer #(
        .CLK_FREQ (12000),
        .TICK_HZ  (1000),
        .GAP_TICKS(0)
    ) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .i_trig(trig_b),
        .i_sfx (sfx),
        .o_freq(freq_b),
        .o_busy(busy_b),
        .o_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Caller sits just after a negedge; the trigger is sampled at the next posedge.
    task automatic trig(input bit on_b, input logic [1:0] s);
        sfx = s;
        if (on_b) trig_b = 1'b1; else trig_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trig_a = 1'b0;
        trig_b = 1'b0;
    endtask

    // Holds for n cycles: freq, busy as given and no done pulse.
    // The count of deviating cycles is compared against zero.
    task automatic seg(input string tag, input bit on_b, input int f, input bit b, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (on_b) begin
                if (freq_b !== 24'(f) || busy_b !== b || done_b !== 1'b0) bad++;
            end else begin
                if (freq_a !== 24'(f) || busy_a !== b || done_a !== 1'b0) bad++;
            end
            @(negedge clk);
        end
        check(tag, bad, 0);
    endtask

    initial begin
        rst    = 1'b1;
        trig_a = 1'b0;
        trig_b = 1'b0;
        sfx    = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_freq_a", freq_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // Laser: full sequence with gaps.
        trig(1'b0, 2'd0);
        seg("laser_880", 1'b0, 880, 1'b1, 600);
        seg("laser_gap1", 1'b0, 0, 1'b1, 120);
        seg("laser_660", 1'b0, 660, 1'b1, 600);
        seg("laser_gap2", 1'b0, 0, 1'b1, 120);
        seg("laser_440", 1'b0, 440, 1'b1, 600);
        check("laser_done", done_a, 1);
        check("laser_done_busy", busy_a, 0);
        check("laser_done_freq", freq_a, 0);
        @(negedge clk);
        check("laser_done_once", done_a, 0);
        seg("laser_idle", 1'b0, 0, 1'b0, 20);

        // Explosion retriggered to coin in the 300th cycle of 110 Hz.
        trig(1'b0, 2'd1);
        seg("expl_110", 1'b0, 110, 1'b1, 299);
        trig(1'b0, 2'd2);
        check("retrig_freq", freq_a, 988);
        seg("coin_988", 1'b0, 988, 1'b1, 720);
        seg("coin_gap", 1'b0, 0, 1'b1, 120);
        seg("coin_1319", 1'b0, 1319, 1'b1, 2400);
        check("coin_done", done_a, 1);
        @(negedge clk);

        // Laser stopped with sfx 3 during the 660 Hz note.
        trig(1'b0, 2'd0);
        seg("stop_880", 1'b0, 880, 1'b1, 600);
        seg("stop_gap", 1'b0, 0, 1'b1, 120);
        seg("stop_660", 1'b0, 660, 1'b1, 100);
        trig(1'b0, 2'd3);
        check("stop_freq", freq_a, 0);
        check("stop_busy", busy_a, 0);
        check("stop_done", done_a, 0);
        seg("stop_idle", 1'b0, 0, 1'b0, 30);

        // Coin retriggered exactly as its last note expires.
        trig(1'b0, 2'd2);
        seg("edge_988", 1'b0, 988, 1'b1, 720);
        seg("edge_gap", 1'b0, 0, 1'b1, 120);
        seg("edge_1319", 1'b0, 1319, 1'b1, 2399);
        check("edge_last_cycle", freq_a, 1319);
        trig(1'b0, 2'd2);
        check("edge_freq", freq_a, 988);
        check("edge_no_done", done_a, 0);
        seg("edge_988b", 1'b0, 988, 1'b1, 50);
        trig(1'b0, 2'd3);

        // Reset together with a trigger during explosion note 80.
        trig(1'b0, 2'd1);
        seg("rst_110", 1'b0, 110, 1'b1, 1200);
        seg("rst_gap", 1'b0, 0, 1'b1, 120);
        seg("rst_80", 1'b0, 80, 1'b1, 50);
        rst    = 1'b1;
        trig_a = 1'b1;
        sfx    = 2'd0;
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        trig_a = 1'b0;
        check("rst_mid_freq", freq_a, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_done", done_a, 0);
        seg("rst_stay_idle", 1'b0, 0, 1'b0, 40);

        // Zero-gap instance: notes run back to back.
        trig(1'b1, 2'd2);
        seg("nogap_988", 1'b1, 988, 1'b1, 720);
        seg("nogap_1319", 1'b1, 1319, 1'b1, 2400);
        check("nogap_done", done_b, 1);
        check("nogap_busy", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
